// File: rtl/multiplier.sv
// Multiply-accumulate unit: product_out = A*B + C, unsigned, full 2*WIDTH result.
// Radix-2 shift-add, one step per clock, fixed latency of WIDTH steps after the accepting edge.
// Requests are taken only while idle; the strobe is ignored while busy_out is high.
module multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [WIDTH-1:0]     multiplicand_in,
  input  logic [WIDTH-1:0]     multiplier_in,
  input  logic [WIDTH-1:0]     addend_in,
  input  logic                 data_valid_in,
  output logic [2*WIDTH-1:0]   product_out,
  output logic                 overflow_out,
  output logic                 data_valid_out,
  output logic                 busy_out
);

  // Counter holds 0..WIDTH so it never wraps inside an operation.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    MULT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 ovf_q, ovf_d;
  logic                 dvo_q, dvo_d;
  logic                 busy_q, busy_d;

  // Accumulator value after the current shift-add step.
  logic [2*WIDTH-1:0]   acc_step;

  // State and datapath registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
      dvo_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      ovf_q    <= ovf_d;
      dvo_q    <= dvo_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and datapath: accept in IDLE, shift-add in MULT, publish on the last step.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    // The result strobe is a single-cycle pulse.
    dvo_d    = 1'b0;
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    case (state_q)
      IDLE: begin
        if (data_valid_in) begin
          mcand_d  = {{WIDTH{1'b0}}, multiplicand_in};
          mplier_d = multiplier_in;
          // Seeding the accumulator with C folds the addition into the multiply for free.
          acc_d    = {{WIDTH{1'b0}}, addend_in};
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = MULT;
        end
      end
      MULT: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Always run all WIDTH steps so latency is data independent.
        if (cnt_q == LAST_STEP) begin
          prod_d  = acc_step;
          ovf_d   = |acc_step[2*WIDTH-1:WIDTH];
          dvo_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign product_out    = prod_q;
  assign overflow_out   = ovf_q;
  assign data_valid_out = dvo_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_multiplier.sv
// Directed bench for the shift-add multiply-accumulate unit.
// Drives two instances (WIDTH=8 and WIDTH=32) with hand-computed vectors.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_multiplier;

  logic clk;
  logic rst;

  logic [7:0]  a8, b8, c8;
  logic        dv8;
  logic [15:0] prod8;
  logic        ovf8, dvo8, busy8;

  logic [31:0] a32, b32, c32;
  logic        dv32;
  logic [63:0] prod32;
  logic        ovf32, dvo32, busy32;

  int n_cmp = 0;
  int n_bad = 0;

  multiplier #(.WIDTH(8)) u_mul8 (
    .clk_in          (clk),
    .rst_in          (rst),
    .multiplicand_in (a8),
    .multiplier_in   (b8),
    .addend_in       (c8),
    .data_valid_in   (dv8),
    .product_out     (prod8),
    .overflow_out    (ovf8),
    .data_valid_out  (dvo8),
    .busy_out        (busy8)
  );

  multiplier #(.WIDTH(32)) u_mul32 (
    .clk_in          (clk),
    .rst_in          (rst),
    .multiplicand_in (a32),
    .multiplier_in   (b32),
    .addend_in       (c32),
    .data_valid_in   (dv32),
    .product_out     (prod32),
    .overflow_out    (ovf32),
    .data_valid_out  (dvo32),
    .busy_out        (busy32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete 8-bit operation with scrambled inputs while busy.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [15:0] ep, input logic eo);
    int nb;
    int nd;
    a8 = a; b8 = b; c8 = c; dv8 = 1'b1;
    tick();
    chk({tag, ":busy_k"}, busy8, 1);
    chk({tag, ":dv_k"}, dvo8, 0);
    dv8 = 1'b0;
    a8 = 8'hA5; b8 = 8'h5A; c8 = 8'h3C;
    nb = 0; nd = 0;
    repeat (7) begin
      tick();
      nb += int'(busy8);
      nd += int'(dvo8);
    end
    chk({tag, ":busy_cycles"}, 64'(nb), 7);
    chk({tag, ":early_dv"}, 64'(nd), 0);
    tick();
    chk({tag, ":dv"}, dvo8, 1);
    chk({tag, ":busy_end"}, busy8, 0);
    chk({tag, ":prod"}, prod8, ep);
    chk({tag, ":ovf"}, ovf8, eo);
    tick();
    chk({tag, ":dv_drop"}, dvo8, 0);
    chk({tag, ":prod_hold"}, prod8, ep);
    chk({tag, ":ovf_hold"}, ovf8, eo);
  endtask

  initial begin
    int nb;
    int nd;
    rst = 1'b1;
    a8 = '0; b8 = '0; c8 = '0; dv8 = 1'b0;
    a32 = '0; b32 = '0; c32 = '0; dv32 = 1'b0;
    #2;
    chk("rst:prod", prod8, 0);
    chk("rst:ovf", ovf8, 0);
    chk("rst:dv", dvo8, 0);
    chk("rst:busy", busy8, 0);
    chk("rst:busy32", busy32, 0);
    tick();
    rst = 1'b0;

    run8("mac_13x11p5", 8'd13, 8'd11, 8'd5, 16'd148, 1'b0);
    run8("max_255", 8'd255, 8'd255, 8'd255, 16'hFF00, 1'b1);

    // Asynchronous reset three cycles into an operation.
    a8 = 8'd100; b8 = 8'd100; c8 = 8'd0; dv8 = 1'b1;
    tick();
    dv8 = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst:prod", prod8, 0);
    chk("arst:ovf", ovf8, 0);
    chk("arst:dv", dvo8, 0);
    chk("arst:busy", busy8, 0);
    #1;
    rst = 1'b0;
    run8("after_rst_6x7", 8'd6, 8'd7, 8'd0, 16'd42, 1'b0);

    run8("zero_a", 8'd0, 8'd200, 8'd7, 16'd7, 1'b0);
    run8("carry_from_c", 8'd1, 8'd1, 8'd255, 16'd256, 1'b1);

    // Back-to-back with ignored strobes mid-operation and at the final edge.
    a8 = 8'd3; b8 = 8'd4; c8 = 8'd0; dv8 = 1'b1;
    tick();
    dv8 = 1'b0;
    repeat (2) tick();
    a8 = 8'd9; b8 = 8'd9; dv8 = 1'b1;
    tick();
    dv8 = 1'b0;
    nd = 0;
    repeat (4) begin
      tick();
      nd += int'(dvo8);
    end
    a8 = 8'd2; b8 = 8'd2; c8 = 8'd1; dv8 = 1'b1;
    tick();
    chk("b2b:early_dv", 64'(nd), 0);
    chk("b2b:dv1", dvo8, 1);
    chk("b2b:prod1", prod8, 12);
    chk("b2b:busy_end1", busy8, 0);
    tick();
    chk("b2b:busy_k9", busy8, 1);
    chk("b2b:dv_drop", dvo8, 0);
    dv8 = 1'b0;
    nd = 0;
    repeat (7) begin
      tick();
      nd += int'(dvo8);
    end
    chk("b2b:mid_dv", 64'(nd), 0);
    tick();
    chk("b2b:dv2", dvo8, 1);
    chk("b2b:prod2", prod8, 5);
    chk("b2b:ovf2", ovf8, 0);
    tick();

    // Full-width operand on the 32-bit instance.
    a32 = 32'hFFFF_FFFF; b32 = 32'd2; c32 = 32'd1; dv32 = 1'b1;
    tick();
    chk("w32:busy_k", busy32, 1);
    dv32 = 1'b0;
    a32 = '0; b32 = '0; c32 = '0;
    nb = 0; nd = 0;
    repeat (31) begin
      tick();
      nb += int'(busy32);
      nd += int'(dvo32);
    end
    chk("w32:busy_cycles", 64'(nb), 31);
    chk("w32:early_dv", 64'(nd), 0);
    tick();
    chk("w32:dv", dvo32, 1);
    chk("w32:prod", prod32, 64'h1_FFFF_FFFF);
    chk("w32:ovf", ovf32, 1);
    chk("w32:busy_end", busy32, 0);
    tick();
    chk("w32:dv_drop", dvo32, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
